// File: rtl/op_dispatcher_if.sv
// Operation descriptor types and the push/issue handshake bundle between host, dispatcher and cpu.
// slave = dispatcher view; master = host/cpu side (testbench).
package op_dispatcher_pkg;
    localparam int NCOEFF  = 64;
    localparam int NPRIMES = 4;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_CT_CT_ADD = 3'd1,
        OP_CT_CT_SUB = 3'd2,
        OP_CT_CT_MUL = 3'd3,
        OP_CT_PT_ADD = 3'd4,
        OP_CT_PT_MUL = 3'd5
    } op_mode_t;

    typedef struct packed {
        op_mode_t           mode;
        logic [IDX_W-1:0]   idx1_a;
        logic [IDX_W-1:0]   idx1_b;
        logic [IDX_W-1:0]   idx2_a;
        logic [IDX_W-1:0]   idx2_b;
        logic [IDX_W-1:0]   out_a;
        logic [IDX_W-1:0]   out_b;
    } operation;
endpackage

interface op_dispatcher_if;
    import op_dispatcher_pkg::*;

    logic     in_valid;
    logic     in_ready;
    operation in_op;
    operation op;
    logic     op_start;
    logic     done_in;

    modport slave  (input  in_valid, in_op, done_in, output in_ready, op, op_start);
    modport master (output in_valid, in_op, done_in, input  in_ready, op, op_start);
endinterface

// File: rtl/op_dispatcher.sv
// Serialising issue stage for cpu: queues descriptors, issues one at a time, head popped on done/timeout.
// Push-to-op_start 2 edges from an idle empty queue; in_ready drops while count == DEPTH.
module op_dispatcher
    import op_dispatcher_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = NCOEFF * NPRIMES + 20,
    parameter int RCNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    op_dispatcher_if.slave               io,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         timeout_err,
    output logic [RCNT_W-1:0]            retired
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state, state_nxt;
    operation         mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [WD_W-1:0]  wd;
    logic             push, pop, load, retire, expire;

    assign io.in_ready = (count != CNT_FULL);
    assign push        = io.in_valid && io.in_ready;
    assign io.op_start = (state == ISSUE);
    assign busy        = (state != IDLE);

    // done_in is only honoured in WAIT, so a level held over IDLE/ISSUE cannot retire the next op.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        retire    = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (io.done_in) begin
                    pop       = 1'b1;
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end else if (wd == WD_LAST) begin
                    pop       = 1'b1;
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            wd          <= '0;
            io.op       <= '0;
            timeout_err <= 1'b0;
            retired     <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (load) io.op <= mem[head];
            if (state == ISSUE)            wd <= '0;
            else if (state == WAIT && !pop) wd <= wd + 1'b1;
            if (retire) retired     <= retired + 1'b1;
            if (expire) timeout_err <= 1'b1;
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= io.in_op;
    end
endmodule

// File: tb/tb_op_dispatcher.sv
// Bench for op_dispatcher: scoreboard of pushed descriptors checked at each op_start, cpu latency model, vector table.
module tb_op_dispatcher;
    import op_dispatcher_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 12;
    localparam int RCNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              busy;
    logic [2:0]        count;
    logic              timeout_err;
    logic [RCNT_W-1:0] retired;

    op_dispatcher_if io();

    op_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .RCNT_W(RCNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .io          (io),
        .busy        (busy),
        .count       (count),
        .timeout_err (timeout_err),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    operation exp_q[$];
    int       n_starts = 0;
    int       cpu_lat = -1;
    int       cpu_cnt = -1;
    bit       hold_done = 1'b0;
    int       exp_ret = 0;

    typedef struct {
        operation d;
        int       lat;
        int       exp_cyc;
        int       ret_inc;
        int       exp_err;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic operation mk(input op_mode_t m, input int a, input int b, input int c,
                                    input int d, input int e, input int f);
        operation o;
        o.mode   = m;
        o.idx1_a = IDX_W'(a);
        o.idx1_b = IDX_W'(b);
        o.idx2_a = IDX_W'(c);
        o.idx2_b = IDX_W'(d);
        o.out_a  = IDX_W'(e);
        o.out_b  = IDX_W'(f);
        return o;
    endfunction

    task automatic push(input operation d);
        int n = 0;
        io.in_valid = 1'b1;
        io.in_op    = d;
        while (!io.in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("push_accept", int'(io.in_ready), 1);
        if (io.in_ready) exp_q.push_back(d);
        tick();
        io.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while ((busy || count != 0) && n < 300) begin
            tick();
            n++;
        end
        chk(name, int'(busy || count != 0), 0);
    endtask

    // cpu model: done_in pulses cpu_lat cycles after op_start is seen (-1 = never), or level while hold_done.
    always @(negedge clk) begin
        if (!reset) begin
            cpu_cnt = -1;
        end else if (io.op_start) begin
            n_starts++;
            if (exp_q.size() == 0) chk("op_start_unexpected", 1, 0);
            else                   chk("op_start_op", int'(io.op), int'(exp_q.pop_front()));
            cpu_cnt = cpu_lat;
        end else if (cpu_cnt >= 0) begin
            cpu_cnt--;
        end
        io.done_in = hold_done || (cpu_cnt == 0);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal;
    end

    initial begin
        int n;
        int base;
        reset       = 1'b0;
        io.in_valid = 1'b0;
        io.in_op    = '0;

        vecs[0] = '{mk(OP_CT_CT_ADD, 0, 1, 2, 3, 4, 5),        10, 11,          1, 0};
        vecs[1] = '{mk(OP_CT_CT_SUB, 5, 4, 3, 2, 1, 0),         1,  2,          1, 0};
        vecs[2] = '{mk(OP_CT_PT_MUL, 2, 2, 3, 3, 6, 6),        11, 12,          1, 0};
        vecs[3] = '{mk(OP_CT_CT_MUL, 9, 8, 7, 6, 5, 4),        12, 13,          1, 0};
        vecs[4] = '{mk(OP_CT_PT_ADD, 1, 3, 5, 7, 9, 11),       -1, TIMEOUT + 1, 0, 1};
        vecs[5] = '{mk(OP_CT_CT_ADD, 15, 14, 13, 12, 11, 10),   2,  3,          1, 1};
        vecs[6] = '{mk(OP_CT_PT_MUL, 4, 4, 4, 4, 4, 4),        13, TIMEOUT + 1, 0, 1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        chk("rst_count",    int'(count), 0);
        chk("rst_busy",     int'(busy), 0);
        chk("rst_in_ready", int'(io.in_ready), 1);
        chk("rst_op",       int'(io.op), 0);
        chk("rst_op_start", int'(io.op_start), 0);
        chk("rst_err",      int'(timeout_err), 0);
        chk("rst_retired",  int'(retired), 0);

        // Fill and backpressure
        cpu_lat = -1;
        for (int i = 0; i < 4; i++) push(mk(OP_CT_CT_ADD, i, 0, 0, 0, 10 + i, 0));
        chk("full_in_ready", int'(io.in_ready), 0);
        chk("full_count",    int'(count), 4);
        cpu_lat     = 2;
        io.in_valid = 1'b1;
        io.in_op    = mk(OP_CT_PT_ADD, 4, 0, 0, 0, 14, 0);
        tick();
        chk("full_no_accept", int'(count), 4);
        hold_done = 1'b1;
        tick();
        hold_done = 1'b0;
        chk("pop_in_ready", int'(io.in_ready), 1);
        chk("pop_count",    int'(count), 3);
        exp_q.push_back(io.in_op);
        tick();
        io.in_valid = 1'b0;
        chk("refill_count", int'(count), 4);
        wait_idle("fill_drain", n);
        exp_ret += 5;
        chk("fill_retired", int'(retired), exp_ret);

        // Ordering through pointer wrap
        cpu_lat = 3;
        base    = n_starts;
        for (int i = 0; i < 10; i++) push(mk(OP_CT_CT_MUL, i, i + 1, 0, 0, i, 9 - i));
        wait_idle("wrap_drain", n);
        chk("wrap_starts", n_starts - base, 10);
        exp_ret += 10;
        chk("wrap_retired", int'(retired), exp_ret);

        // Single-op vectors: latency, coincidence, timeout, late done
        for (int i = 0; i < 7; i++) begin
            cpu_lat = vecs[i].lat;
            push(vecs[i].d);
            tick();
            chk($sformatf("vec%0d_op_start", i), int'(io.op_start), 1);
            chk($sformatf("vec%0d_op", i), int'(io.op), int'(vecs[i].d));
            wait_idle($sformatf("vec%0d_idle", i), n);
            chk($sformatf("vec%0d_cycles", i), n, vecs[i].exp_cyc);
            exp_ret += vecs[i].ret_inc;
            chk($sformatf("vec%0d_retired", i), int'(retired), exp_ret);
            chk($sformatf("vec%0d_err", i), int'(timeout_err), vecs[i].exp_err);
        end
        repeat (3) tick();
        chk("late_done_ignored", int'(retired), exp_ret);

        // done_in held across IDLE and ISSUE must retire only the first op
        cpu_lat = -1;
        push(mk(OP_CT_PT_MUL, 1, 1, 1, 1, 1, 1));
        push(mk(OP_CT_PT_MUL, 2, 2, 2, 2, 2, 2));
        tick();
        hold_done = 1'b1;
        repeat (3) tick();
        hold_done = 1'b0;
        chk("held_retired", int'(retired), exp_ret + 1);
        chk("held_busy",    int'(busy), 1);
        chk("held_count",   int'(count), 1);
        tick();
        hold_done = 1'b1;
        tick();
        hold_done = 1'b0;
        tick();
        exp_ret += 2;
        chk("held_final_retired", int'(retired), exp_ret);
        chk("held_final_count",   int'(count), 0);

        // Async reset mid-WAIT with three ops queued
        cpu_lat = -1;
        for (int i = 0; i < 3; i++) push(mk(OP_CT_CT_SUB, i, i, i, i, i, i));
        tick();
        chk("pre_rst_count", int'(count), 3);
        #2 reset = 1'b0;
        #1;
        chk("arst_count",    int'(count), 0);
        chk("arst_busy",     int'(busy), 0);
        chk("arst_op",       int'(io.op), 0);
        chk("arst_op_start", int'(io.op_start), 0);
        chk("arst_in_ready", int'(io.in_ready), 1);
        chk("arst_retired",  int'(retired), 0);
        chk("arst_err",      int'(timeout_err), 0);
        exp_q.delete();
        exp_ret = 0;
        tick();
        tick();
        reset = 1'b1;

        cpu_lat = 4;
        push(mk(OP_CT_CT_SUB, 7, 6, 5, 4, 3, 2));
        tick();
        chk("post_rst_op_start", int'(io.op_start), 1);
        wait_idle("post_rst_idle", n);
        chk("post_rst_cycles",  n, 5);
        chk("post_rst_retired", int'(retired), 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/op_dispatcher.md
# op_dispatcher

Upstream issue stage for `cpu`. It buffers `operation` descriptors (mode plus the `idx1_a/idx1_b/idx2_a/idx2_b/out_a/out_b` polynomial indices) from the host/test sequencer in a small FIFO. It presents one descriptor at a time on the `cpu` `op` input, holding it stable until `cpu` raises `done_out`. This makes CT–CT and CT–PT ops strictly serialised, so back-to-back ops never have a register-file hazard. A watchdog bounds each op.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, default `NCOEFF*NPRIMES+20`: max cycles in WAIT before the op is abandoned.
- `RCNT_W`, default 16: width of the retired-op counter.

- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; asserting it (0) clears all state immediately; deassertion is synchronous to `clk` by the integrator.
- `in_valid` in 1: `in_op` holds a descriptor.
- `in_ready` out 1: FIFO can accept; equals `count != DEPTH` (combinational from registered count).
- `in_op` in `operation`: descriptor to enqueue.
- `op` out `operation`: descriptor driven to `cpu.op`; registered.
- `op_start` out 1: one-cycle pulse marking the first cycle a new `op` is valid.
- `done_in` in 1: from `cpu.done_out`.
- `busy` out 1: state ≠ IDLE.
- `count` out `$clog2(DEPTH+1)`: FIFO occupancy, including the in-flight entry.
- `timeout_err` out 1: sticky; set on any watchdog expiry.
- `retired` out `RCNT_W`: ops completed via `done_in`; wraps modulo 2^RCNT_W.

## Operation
- The FIFO is a circular buffer with a head and a tail pointer, each `$clog2(DEPTH)` bits, wrapping at DEPTH.
- Push: occurs when `in_valid && in_ready`; writes `in_op` at tail, advances tail, and increments count.
- The head entry is not popped at issue. It is popped only on completion or timeout, so `count` includes the executing op.
- Push and pop in the same cycle: both take effect and `count` is unchanged. When full, `in_ready`=0, so no push occurs even if a pop happens that cycle.
- State machine, one-hot or encoded:
  - IDLE: if `count != 0`, load `op` ← FIFO[head] and go to ISSUE. `done_in` is ignored.
  - ISSUE: `op_start`=1 and the watchdog counter is cleared to 0. Always go to WAIT. `done_in` is ignored.
  - WAIT: `op` is held.
    - If `done_in`: pop head, `retired` += 1, go to IDLE.
    - Else if watchdog == TIMEOUT-1: pop head, set `timeout_err`, go to IDLE (`retired` is unchanged).
    - Else: watchdog += 1.
- If `done_in` and watchdog expiry coincide, `done_in` wins: the op is counted as retired and no error is raised.
- `op` keeps the last issued descriptor while IDLE; it is never changed outside the IDLE→ISSUE transition.
- Watchdog width: `$clog2(TIMEOUT)` bits, saturating-safe because it is compared with ==.
- `timeout_err` is cleared only by reset.

## Timing
- Reset values: `op`='0, `op_start`=0, `busy`=0, `count`=0, `in_ready`=1, `timeout_err`=0, `retired`=0. State=IDLE; pointers and watchdog are 0. FIFO storage is not reset.
- Reset mid-operation: an in-flight op is dropped without any pulse. `cpu` is expected to be reset concurrently.
- Latency, with an empty FIFO in IDLE and a push accepted at edge E0:
  - `op` is loaded and state=ISSUE after E1, so `op_start` is high between E1 and E2.
  - State is WAIT after E2.
- When `done_in` is sampled high at edge Ed:
  - Pop and state=IDLE after Ed.
  - The next queued op has state=ISSUE after Ed+1.
  - Minimum start-to-start spacing is therefore 3 cycles plus cpu latency.
- `done_in` must be high for ≥1 cycle while in WAIT. A level held across the WAIT→IDLE transition is ignored in IDLE and ISSUE, so it cannot retire the next op early.
- Timeout: with `done_in` never asserted, the op is abandoned at the TIMEOUT-th WAIT edge after ISSUE.

## Test plan
- Single CT–CT add: push `{OP_CT_CT_ADD, 0,1,2,3,4,5}`, cpu model raises `done_in` 10 cycles after `op_start`.
  - `op_start` high exactly one cycle, 1 cycle after the push edge; `op` matches the pushed descriptor.
  - `retired`=1, `count`=0, `busy`=0.
- Fill/backpressure with DEPTH=4: push 5 ops while `done_in`=0.
  - `in_ready` drops after the 4th push; the 5th is not accepted; `count`=4.
  - After one `done_in`, `in_ready`=1 and the 5th is accepted.
- Ordering and wrap: push 10 ops with distinct `out_a` 0..9, `done_in` after 3 WAIT cycles each.
  - The `op_start` sequence shows `out_a` 0..9 in order; pointers wrap; `retired`=10.
- Timeout with TIMEOUT=8: never assert `done_in`.
  - `timeout_err`=1 after the 8th WAIT edge; `count` decrements; `retired`=0.
  - The next op issues normally and `timeout_err` stays 1.
- Coincidence: `done_in` asserted on the same edge the watchdog hits TIMEOUT-1.
  - `retired` increments and `timeout_err` stays 0.
  - Held `done_in` during IDLE/ISSUE does not retire the following op.
- Async reset mid-WAIT with 3 ops queued: drive `reset`=0 between clock edges.
  - All outputs take reset values immediately (`count`=0, `busy`=0, `op`='0).
  - After release, a new push issues normally.
